// File: rtl/hw5_alu_sequencer.sv
// Command sequencer for a 16-bit four-function combinational ALU. It keeps a small register
// file and builds SUB and OR out of several primitive ALU passes, one pass per clock.
module hw5_alu_sequencer #(
    parameter int WIDTH = 16,
    parameter int NREGS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_op,
    input  logic [$clog2(NREGS)-1:0] cmd_rd,
    input  logic [$clog2(NREGS)-1:0] cmd_rs1,
    input  logic [$clog2(NREGS)-1:0] cmd_rs2,
    input  logic [WIDTH-1:0]         cmd_imm,
    output logic [WIDTH-1:0]         aluin1,
    output logic [WIDTH-1:0]         aluin2,
    output logic [1:0]               alu_control,
    input  logic [WIDTH-1:0]         aluout,
    input  logic                     alu_carry,
    output logic                     rsp_valid,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     rsp_carry,
    output logic                     rsp_err
);
    localparam int IDXW = $clog2(NREGS);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_AND = 3'd1;
    localparam logic [2:0] OP_NOT = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_LDI = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;

    localparam logic [1:0] ALU_ADD  = 2'd0;
    localparam logic [1:0] ALU_AND  = 2'd1;
    localparam logic [1:0] ALU_NOT  = 2'd2;
    localparam logic [1:0] ALU_ZERO = 2'd3;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_PASS,
        S_RESP
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [2:0]        r_op;
    logic [IDXW-1:0]   r_rd;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_t;
    logic [WIDTH-1:0]  r_x;
    logic              r_c1;
    logic [1:0]        r_pass;
    logic [WIDTH-1:0]  r_rsp_data;
    logic              r_rsp_carry;
    logic              r_rsp_err;
    logic [WIDTH-1:0]  r_regs [NREGS];

    logic              w_accept;
    logic              w_cmd_is_alu;
    logic [1:0]        w_ctrl;
    logic [WIDTH-1:0]  w_in1;
    logic [WIDTH-1:0]  w_in2;
    logic              w_last;
    logic              w_to_x;
    logic              w_fin_carry;
    logic              w_wb_en;
    logic [IDXW-1:0]   w_wb_rd;
    logic [WIDTH-1:0]  w_wb_data;
    logic [NREGS-1:0]  w_wr_sel;

    assign w_accept     = cmd_valid && (r_state == S_IDLE);
    assign w_cmd_is_alu = (cmd_op == OP_ADD) || (cmd_op == OP_AND) || (cmd_op == OP_NOT) ||
                          (cmd_op == OP_SUB) || (cmd_op == OP_OR);

    // Per-pass ALU programme; T holds intermediates, X is only used by OR's first pass.
    always_comb begin
        w_ctrl = ALU_ZERO;
        w_in1  = '0;
        w_in2  = '0;
        w_last = 1'b0;
        w_to_x = 1'b0;
        if (r_state == S_PASS) begin
            case (r_op)
                OP_ADD: begin
                    w_ctrl = ALU_ADD; w_in1 = r_a; w_in2 = r_b; w_last = 1'b1;
                end
                OP_AND: begin
                    w_ctrl = ALU_AND; w_in1 = r_a; w_in2 = r_b; w_last = 1'b1;
                end
                OP_NOT: begin
                    w_ctrl = ALU_NOT; w_in1 = r_a; w_last = 1'b1;
                end
                OP_SUB: begin
                    case (r_pass)
                        2'd0:    begin w_ctrl = ALU_NOT; w_in1 = r_b; end
                        2'd1:    begin w_ctrl = ALU_ADD; w_in1 = r_t; w_in2 = ONE; end
                        default: begin w_ctrl = ALU_ADD; w_in1 = r_a; w_in2 = r_t; w_last = 1'b1; end
                    endcase
                end
                OP_OR: begin
                    case (r_pass)
                        2'd0:    begin w_ctrl = ALU_NOT; w_in1 = r_a; w_to_x = 1'b1; end
                        2'd1:    begin w_ctrl = ALU_NOT; w_in1 = r_b; end
                        2'd2:    begin w_ctrl = ALU_AND; w_in1 = r_x; w_in2 = r_t; end
                        default: begin w_ctrl = ALU_NOT; w_in1 = r_t; w_last = 1'b1; end
                    endcase
                end
                default: ;
            endcase
        end
    end

    // SUB's no-borrow is the OR of both increment carries: B=0 makes ~B+1 wrap.
    always_comb begin
        w_fin_carry = 1'b0;
        if (r_op == OP_ADD)
            w_fin_carry = alu_carry;
        else if (r_op == OP_SUB)
            w_fin_carry = r_c1 | alu_carry;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_next = w_cmd_is_alu ? S_PASS : S_RESP;
            S_PASS: if (w_last)   w_state_next = S_RESP;
            S_RESP: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_wb_en   = 1'b0;
        w_wb_rd   = r_rd;
        w_wb_data = aluout;
        if (w_accept && (cmd_op == OP_LDI)) begin
            w_wb_en   = 1'b1;
            w_wb_rd   = cmd_rd;
            w_wb_data = cmd_imm;
        end else if ((r_state == S_PASS) && w_last) begin
            w_wb_en = 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_wsel
            assign w_wr_sel[gi] = w_wb_en && (w_wb_rd == IDXW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++)
                if (w_wr_sel[i]) r_regs[i] <= w_wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_rd        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_t         <= '0;
            r_x         <= '0;
            r_c1        <= 1'b0;
            r_pass      <= '0;
            r_rsp_data  <= '0;
            r_rsp_carry <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_op   <= cmd_op;
                r_rd   <= cmd_rd;
                r_a    <= r_regs[cmd_rs1];
                r_b    <= r_regs[cmd_rs2];
                r_pass <= '0;
                r_c1   <= 1'b0;
                if (!w_cmd_is_alu) begin
                    r_rsp_data  <= (cmd_op == OP_LDI) ? cmd_imm : '0;
                    r_rsp_carry <= 1'b0;
                    r_rsp_err   <= (cmd_op != OP_LDI);
                end
            end
            if (r_state == S_PASS) begin
                r_pass <= w_last ? 2'd0 : r_pass + 2'd1;
                if (w_to_x)
                    r_x <= aluout;
                else
                    r_t <= aluout;
                if ((r_op == OP_SUB) && (r_pass == 2'd1))
                    r_c1 <= alu_carry;
                if (w_last) begin
                    r_rsp_data  <= aluout;
                    r_rsp_carry <= w_fin_carry;
                    r_rsp_err   <= 1'b0;
                end
            end
        end
    end

    assign cmd_ready   = (r_state == S_IDLE);
    assign rsp_valid   = (r_state == S_RESP);
    assign rsp_data    = r_rsp_data;
    assign rsp_carry   = r_rsp_carry;
    assign rsp_err     = r_rsp_err;
    assign alu_control = w_ctrl;
    assign aluin1      = w_in1;
    assign aluin2      = w_in2;

endmodule

// File: tb/tb_hw5_alu_sequencer.sv
// Scoreboard bench for hw5_alu_sequencer: directed commands push expected responses,
// a negedge monitor pops and compares data, carry, error flag and arrival cycle.
module tb_hw5_alu_sequencer;
    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [1:0]  cmd_rd;
    logic [1:0]  cmd_rs1;
    logic [1:0]  cmd_rs2;
    logic [15:0] cmd_imm;
    logic [15:0] aluin1;
    logic [15:0] aluin2;
    logic [1:0]  alu_control;
    logic [15:0] aluout;
    logic        alu_carry;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_carry;
    logic        rsp_err;

    hw5_alu_sequencer #(.WIDTH(16), .NREGS(4)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
        .aluin1(aluin1), .aluin2(aluin2), .alu_control(alu_control),
        .aluout(aluout), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_err(rsp_err)
    );

    // Reference combinational ALU.
    always_comb begin
        aluout    = '0;
        alu_carry = 1'b0;
        case (alu_control)
            2'd0: {alu_carry, aluout} = {1'b0, aluin1} + {1'b0, aluin2};
            2'd1: aluout = aluin1 & aluin2;
            2'd2: aluout = ~aluin1;
            default: ;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] d;
        logic        c;
        logic        e;
        int          at;
        string       name;
    } exp_t;
    exp_t q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int lat(input logic [2:0] op);
        case (op)
            3'd0, 3'd1, 3'd2: return 2;
            3'd3:             return 4;
            3'd5:             return 5;
            default:          return 1;
        endcase
    endfunction

    // Monitor: every rsp_valid cycle is one response.
    always @(negedge clk) begin
        if (!reset && rsp_valid) begin
            chk("ready_in_resp", 32'(cmd_ready), 32'd0);
            if (q.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                $display("rsp %-12s cyc=%0d data=%h carry=%b err=%b (exp %h %b %b @%0d)",
                         e.name, cyc, rsp_data, rsp_carry, rsp_err, e.d, e.c, e.e, e.at);
                chk({e.name, "_data"},  32'(rsp_data),  32'(e.d));
                chk({e.name, "_carry"}, 32'(rsp_carry), 32'(e.c));
                chk({e.name, "_err"},   32'(rsp_err),   32'(e.e));
                chk({e.name, "_cycle"}, 32'(cyc),       32'(e.at));
            end
        end
    end

    // alu_control trace; any non-zero-op cycle is a PASS cycle.
    logic [1:0] trace[$];
    bit trace_on = 0;
    always @(negedge clk) begin
        if (!reset && alu_control != 2'd3) begin
            chk("ready_in_pass", 32'(cmd_ready), 32'd0);
            if (trace_on) trace.push_back(alu_control);
        end
    end

    task automatic issue(input string name, input logic [2:0] op, input logic [1:0] rd,
                         input logic [1:0] rs1, input logic [1:0] rs2, input logic [15:0] imm,
                         input logic [15:0] ed, input logic ec, input logic ee, input bit push);
        bit done = 0;
        cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
        cmd_valid = 1'b1;
        for (int t = 0; t < 40 && !done; t++) begin
            if (cmd_ready) begin
                if (push) q.push_back('{d: ed, c: ec, e: ee, at: cyc + lat(op), name: name});
                done = 1;
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        if (!done) chk({name, "_accept_timeout"}, 32'(done), 32'd1);
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain_pending", 32'(q.size()), 32'd0);
    endtask

    initial begin
        logic [1:0]  exp_tr[4];
        logic [15:0] val;
        int          acc;
        exp_tr = '{2'd2, 2'd2, 2'd1, 2'd2};
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0;
        cmd_imm = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_carry", 32'(rsp_carry), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_aluin1", 32'(aluin1), 32'd0);
        chk("rst_aluin2", 32'(aluin2), 32'd0);
        chk("rst_alu_control", 32'(alu_control), 32'd3);

        // ADD with carry out
        issue("ldi_r0", 3'd4, 2'd0, 2'd0, 2'd0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1);
        issue("ldi_r1", 3'd4, 2'd1, 2'd0, 2'd0, 16'h0001, 16'h0001, 1'b0, 1'b0, 1);
        issue("add_wrap", 3'd0, 2'd2, 2'd0, 2'd1, 16'h0, 16'h0000, 1'b1, 1'b0, 1);

        // SUB, both borrow directions and B=0
        issue("ldi_r0_5", 3'd4, 2'd0, 2'd0, 2'd0, 16'd5, 16'd5, 1'b0, 1'b0, 1);
        issue("ldi_r1_3", 3'd4, 2'd1, 2'd0, 2'd0, 16'd3, 16'd3, 1'b0, 1'b0, 1);
        issue("sub_5m3", 3'd3, 2'd2, 2'd0, 2'd1, 16'h0, 16'h0002, 1'b1, 1'b0, 1);
        issue("sub_3m5", 3'd3, 2'd3, 2'd1, 2'd0, 16'h0, 16'hFFFE, 1'b0, 1'b0, 1);
        issue("ldi_r1_0", 3'd4, 2'd1, 2'd0, 2'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1);
        issue("sub_5m0", 3'd3, 2'd2, 2'd0, 2'd1, 16'h0, 16'h0005, 1'b1, 1'b0, 1);

        // OR / AND / NOT with alu_control trace on OR
        issue("ldi_f0f0", 3'd4, 2'd0, 2'd0, 2'd0, 16'hF0F0, 16'hF0F0, 1'b0, 1'b0, 1);
        issue("ldi_0ff0", 3'd4, 2'd1, 2'd0, 2'd0, 16'h0FF0, 16'h0FF0, 1'b0, 1'b0, 1);
        drain();
        trace.delete();
        trace_on = 1;
        issue("or", 3'd5, 2'd2, 2'd0, 2'd1, 16'h0, 16'hFFF0, 1'b0, 1'b0, 1);
        drain();
        trace_on = 0;
        chk("or_trace_len", 32'(trace.size()), 32'd4);
        for (int i = 0; i < 4 && i < trace.size(); i++)
            chk($sformatf("or_trace_%0d", i), 32'(trace[i]), 32'(exp_tr[i]));
        issue("and", 3'd1, 2'd3, 2'd0, 2'd1, 16'h0, 16'h00F0, 1'b0, 1'b0, 1);
        issue("not", 3'd2, 2'd3, 2'd0, 2'd0, 16'h0, 16'h0F0F, 1'b0, 1'b0, 1);

        // Illegal opcodes leave the register file untouched
        issue("ldi_r3_0", 3'd4, 2'd3, 2'd0, 2'd0, 16'h0, 16'h0000, 1'b0, 1'b0, 1);
        issue("illegal6", 3'd6, 2'd2, 2'd0, 2'd1, 16'h1234, 16'h0000, 1'b0, 1'b1, 1);
        issue("rb_r2", 3'd0, 2'd1, 2'd2, 2'd3, 16'h0, 16'hFFF0, 1'b0, 1'b0, 1);
        issue("illegal7", 3'd7, 2'd0, 2'd0, 2'd0, 16'h5555, 16'h0000, 1'b0, 1'b1, 1);
        issue("rb_r0", 3'd0, 2'd2, 2'd0, 2'd3, 16'h0, 16'hF0F0, 1'b0, 1'b0, 1);
        drain();

        // Reset in SUB's second pass: no response, everything cleared
        issue("sub_abort", 3'd3, 2'd2, 2'd0, 2'd1, 16'h0, 16'h0, 1'b0, 1'b0, 0);
        @(posedge clk); #1;
        chk("abort_in_pass2_ctrl", 32'(alu_control), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("post_rst_ready", 32'(cmd_ready), 32'd1);
        chk("post_rst_data", 32'(rsp_data), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        for (int r = 0; r < 4; r++)
            issue($sformatf("rb_zero_r%0d", r), 3'd1, 2'(r), 2'(r), 2'(r), 16'h0,
                  16'h0000, 1'b0, 1'b0, 1);
        drain();

        // Back-to-back ADD R0=R0+R0 with valid held high
        issue("ldi_r0_1", 3'd4, 2'd0, 2'd0, 2'd0, 16'd1, 16'd1, 1'b0, 1'b0, 1);
        cmd_op = 3'd0; cmd_rd = 2'd0; cmd_rs1 = 2'd0; cmd_rs2 = 2'd0; cmd_imm = '0;
        cmd_valid = 1'b1;
        acc = 0;
        val = 16'd1;
        for (int t = 0; t < 50 && acc < 3; t++) begin
            if (cmd_ready) begin
                val = val << 1;
                q.push_back('{d: val, c: 1'b0, e: 1'b0, at: cyc + 2,
                              name: $sformatf("b2b_%0d", acc)});
                acc++;
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        chk("b2b_accepts", 32'(acc), 32'd3);
        drain();

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end
endmodule
